// File: rtl/jump_ctl.sv
// Jump/branch controller: resolves decoded branch ops into a combinational
// jump request for the PC, with a programmable target LUT and a call/return stack.
module jump_ctl #(
    parameter int D  = 9,
    parameter int LW = 4,
    parameter int SD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [D-1:0]              prog_ctr,
    input  logic [2:0]                br_op,
    input  logic [LW-1:0]             lut_idx,
    input  logic                      flag_z,
    input  logic                      lut_we,
    input  logic [LW-1:0]             lut_waddr,
    input  logic [D-1:0]              lut_wdata,
    output logic                      jb_en,
    output logic [D-1:0]              target,
    output logic [$clog2(SD+1)-1:0]   depth,
    output logic                      stk_ovf,
    output logic                      stk_unf
);

    localparam int DW = $clog2(SD + 1);
    localparam int LN = 1 << LW;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BNE  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [D-1:0] lut [LN];
    logic [D-1:0] stk [SD];

    logic [D-1:0] lut_rd;
    logic [D-1:0] stk_top;
    logic [D-1:0] ret_addr;
    logic [D-1:0] tgt;
    logic         full;
    logic         empty;
    logic         take;
    logic         push;
    logic         pop;
    logic         ovf_set;
    logic         unf_set;

    // LUT read sees the pre-edge contents, so a same-cycle write is not bypassed.
    assign lut_rd   = lut[lut_idx];
    assign full     = (depth == DW'(SD));
    assign empty    = (depth == '0);
    assign ret_addr = prog_ctr + D'(1);

    always_comb begin
        stk_top = '0;
        for (int i = 0; i < SD; i++) begin
            if (depth == DW'(i + 1)) begin
                stk_top = stk[i];
            end
        end
    end

    always_comb begin
        take    = 1'b0;
        tgt     = '0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (br_op)
            OP_JMP: begin
                take = 1'b1;
                tgt  = lut_rd;
            end
            OP_BEQ: begin
                take = flag_z;
                tgt  = flag_z ? lut_rd : '0;
            end
            OP_BNE: begin
                take = ~flag_z;
                tgt  = flag_z ? '0 : lut_rd;
            end
            OP_CALL: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    take = 1'b1;
                    tgt  = lut_rd;
                    push = 1'b1;
                end
            end
            OP_RET: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    take = 1'b1;
                    tgt  = stk_top;
                    pop  = 1'b1;
                end
            end
            OP_NONE: ;
            default: ;
        endcase
    end

    // Reset gates the request so the PC never sees a jump while held in reset.
    assign jb_en  = reset & take;
    assign target = reset ? tgt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LN; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SD; i++) begin
                stk[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < SD; i++) begin
                if (depth == DW'(i)) begin
                    stk[i] <= ret_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth   <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            if (push) begin
                depth <= depth + DW'(1);
            end else if (pop) begin
                depth <= depth - DW'(1);
            end
            if (ovf_set) begin
                stk_ovf <= 1'b1;
            end
            if (unf_set) begin
                stk_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jump_ctl.sv
// Directed plus randomized bench for jump_ctl, checked against a queue/array
// model of the LUT, return stack and sticky fault flags.
module tb_jump_ctl;

    localparam int D  = 9;
    localparam int LW = 4;
    localparam int SD = 4;

    logic         clk;
    logic         reset;
    logic [D-1:0] prog_ctr;
    logic [2:0]   br_op;
    logic [LW-1:0] lut_idx;
    logic         flag_z;
    logic         lut_we;
    logic [LW-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    logic         jb_en;
    logic [D-1:0] target;
    logic [2:0]   depth;
    logic         stk_ovf;
    logic         stk_unf;

    jump_ctl #(.D(D), .LW(LW), .SD(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_ctr  (prog_ctr),
        .br_op     (br_op),
        .lut_idx   (lut_idx),
        .flag_z    (flag_z),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .jb_en     (jb_en),
        .target    (target),
        .depth     (depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [D-1:0] lut_m [1 << LW];
    logic [D-1:0] stk_q [$];
    logic         ovf_m;
    logic         unf_m;

    task automatic model_reset();
        for (int i = 0; i < (1 << LW); i++) lut_m[i] = '0;
        stk_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one op at a negedge, checks the jump request, clocks it, checks state.
    task automatic do_op(input logic [2:0] op, input logic [LW-1:0] idx, input logic fz,
                         input logic [D-1:0] pc, input logic we, input logic [LW-1:0] wa,
                         input logic [D-1:0] wd, input string tag);
        logic         exp_jb;
        logic [D-1:0] exp_t;
        logic [D-1:0] ra;
        br_op     = op;
        lut_idx   = idx;
        flag_z    = fz;
        prog_ctr  = pc;
        lut_we    = we;
        lut_waddr = wa;
        lut_wdata = wd;
        exp_jb = 1'b0;
        exp_t  = '0;
        case (op)
            3'd1: begin exp_jb = 1'b1; exp_t = lut_m[idx]; end
            3'd2: if (fz)  begin exp_jb = 1'b1; exp_t = lut_m[idx]; end
            3'd3: if (!fz) begin exp_jb = 1'b1; exp_t = lut_m[idx]; end
            3'd4: if (stk_q.size() < SD) begin exp_jb = 1'b1; exp_t = lut_m[idx]; end
            3'd5: if (stk_q.size() > 0) begin exp_jb = 1'b1; exp_t = stk_q[$]; end
            default: ;
        endcase
        #1;
        check({tag, ".jb_en"}, 32'(jb_en), 32'(exp_jb));
        check({tag, ".target"}, 32'(target), 32'(exp_t));
        @(posedge clk);
        if (we) lut_m[wa] = wd;
        ra = pc + 9'd1;
        if (op == 3'd4) begin
            if (stk_q.size() < SD) stk_q.push_back(ra);
            else ovf_m = 1'b1;
        end else if (op == 3'd5) begin
            if (stk_q.size() > 0) void'(stk_q.pop_back());
            else unf_m = 1'b1;
        end
        @(negedge clk);
        check({tag, ".depth"}, 32'(depth), 32'(stk_q.size()));
        check({tag, ".stk_ovf"}, 32'(stk_ovf), 32'(ovf_m));
        check({tag, ".stk_unf"}, 32'(stk_unf), 32'(unf_m));
    endtask

    initial begin
        reset     = 1'b0;
        prog_ctr  = '0;
        br_op     = 3'b001;
        lut_idx   = '0;
        flag_z    = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        model_reset();

        #2;
        check("rst.jb_en", 32'(jb_en), 32'd0);
        check("rst.target", 32'(target), 32'd0);
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.ovf", 32'(stk_ovf), 32'd0);
        check("rst.unf", 32'(stk_unf), 32'd0);
        @(negedge clk);
        br_op = 3'b000;
        reset = 1'b1;

        // LUT write, then JMP; same-cycle write returns old value
        do_op(3'd0, 4'd0, 1'b0, 9'h000, 1'b1, 4'd3, 9'h1A5, "wr3");
        do_op(3'd1, 4'd3, 1'b0, 9'h001, 1'b0, 4'd0, 9'h000, "jmp3");
        check("jmp3.const", 32'(lut_m[3]), 32'h1A5);
        do_op(3'd1, 4'd3, 1'b0, 9'h002, 1'b1, 4'd3, 9'h0F0, "jmp3_wr");
        do_op(3'd1, 4'd3, 1'b0, 9'h003, 1'b0, 4'd0, 9'h000, "jmp3_new");

        // conditional branches
        do_op(3'd0, 4'd0, 1'b0, 9'h004, 1'b1, 4'd5, 9'h040, "wr5");
        do_op(3'd2, 4'd5, 1'b1, 9'h005, 1'b0, 4'd0, 9'h000, "beq_t");
        do_op(3'd2, 4'd5, 1'b0, 9'h006, 1'b0, 4'd0, 9'h000, "beq_nt");
        do_op(3'd3, 4'd5, 1'b0, 9'h007, 1'b0, 4'd0, 9'h000, "bne_t");
        do_op(3'd3, 4'd5, 1'b1, 9'h008, 1'b0, 4'd0, 9'h000, "bne_nt");

        // nesting, including PC wrap on the pushed address
        do_op(3'd0, 4'd0, 1'b0, 9'h009, 1'b1, 4'd1, 9'h100, "wr1");
        do_op(3'd4, 4'd1, 1'b0, 9'h010, 1'b0, 4'd0, 9'h000, "call1");
        do_op(3'd4, 4'd1, 1'b0, 9'h020, 1'b0, 4'd0, 9'h000, "call2");
        do_op(3'd4, 4'd1, 1'b0, 9'h1FF, 1'b0, 4'd0, 9'h000, "call3");
        check("nest.depth", 32'(depth), 32'd3);
        do_op(3'd5, 4'd0, 1'b0, 9'h100, 1'b0, 4'd0, 9'h000, "ret1");
        do_op(3'd5, 4'd0, 1'b0, 9'h000, 1'b0, 4'd0, 9'h000, "ret2");
        do_op(3'd5, 4'd0, 1'b0, 9'h021, 1'b0, 4'd0, 9'h000, "ret3");

        // underflow stays sticky across a valid call/return pair
        do_op(3'd5, 4'd0, 1'b0, 9'h011, 1'b0, 4'd0, 9'h000, "ret_unf");
        do_op(3'd4, 4'd5, 1'b0, 9'h030, 1'b0, 4'd0, 9'h000, "pair_call");
        do_op(3'd5, 4'd0, 1'b0, 9'h040, 1'b0, 4'd0, 9'h000, "pair_ret");
        check("unf.sticky", 32'(stk_unf), 32'd1);

        // overflow
        for (int i = 0; i < 5; i++)
            do_op(3'd4, 4'd1, 1'b0, 9'(9'h100 + i), 1'b0, 4'd0, 9'h000, "ovf_call");
        check("ovf.depth", 32'(depth), 32'd4);
        do_op(3'd5, 4'd0, 1'b0, 9'h050, 1'b0, 4'd0, 9'h000, "ovf_ret");

        // reserved ops with a non-empty stack
        do_op(3'd6, 4'd3, 1'b1, 9'h060, 1'b0, 4'd0, 9'h000, "rsv6");
        do_op(3'd7, 4'd3, 1'b0, 9'h061, 1'b0, 4'd0, 9'h000, "rsv7");

        // randomized ops against the model
        for (int n = 0; n < 400; n++) begin
            do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 9'($urandom_range(0, 511)), "rnd");
        end

        // asynchronous reset mid-cycle while a CALL is presented
        do_op(3'd0, 4'd0, 1'b0, 9'h000, 1'b1, 4'd3, 9'h155, "pre_rst_wr");
        br_op    = 3'b100;
        lut_idx  = 4'd3;
        prog_ctr = 9'h070;
        lut_we   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst.jb_en", 32'(jb_en), 32'd0);
        check("arst.target", 32'(target), 32'd0);
        check("arst.depth", 32'(depth), 32'd0);
        check("arst.ovf", 32'(stk_ovf), 32'd0);
        check("arst.unf", 32'(stk_unf), 32'd0);
        br_op = 3'b001;
        #1;
        check("arst.jmp_gated", 32'(jb_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(3'd1, 4'd3, 1'b0, 9'h080, 1'b0, 4'd0, 9'h000, "post_rst_jmp");
        do_op(3'd5, 4'd0, 1'b0, 9'h081, 1'b0, 4'd0, 9'h000, "post_rst_ret");

        br_op  = 3'b000;
        lut_we = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jump_ctl.md
# jump_ctl

Jump/branch controller that drives the program counter's jump interface (`jb_en`, `target`) from decoded branch ops. It sits between the decoder and the PC. It takes the current `prog_ctr` back as an input, resolves the branch op, and presents the jump request the PC samples at the next clock edge. Targets come from a programmable lookup table (LUT), or from an internal call/return stack of return addresses.

## Interface
- `D`, 9: PC / target width in bits.
- `LW`, 4: LUT index width; the LUT has 2^LW entries of D bits.
- `SD`, 4: return-stack depth in entries, 1..8.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `prog_ctr`  in  D  current PC value, from the PC.
- `br_op`  in  3  decoded branch op:
  - 000 none
  - 001 JMP
  - 010 BEQ
  - 011 BNE
  - 100 CALL
  - 101 RET
  - 110 and 111 reserved, treated as none.
- `lut_idx`  in  LW  LUT index used by JMP, BEQ, BNE and CALL.
- `flag_z`  in  1  zero flag from the ALU flag register.
- `lut_we`  in  1  LUT write enable.
- `lut_waddr`  in  LW  LUT write index.
- `lut_wdata`  in  D  LUT write data.
- `jb_en`  out  1  jump enable to the PC; combinational.
- `target`  out  D  jump target to the PC; combinational.
- `depth`  out  $clog2(SD+1)  current number of stack entries.
- `stk_ovf`  out  1  sticky: a CALL was attempted with the stack full.
- `stk_unf`  out  1  sticky: a RET was attempted with the stack empty.

## Operation
- Ops are resolved combinationally in the cycle they are presented. When the op is not taken: `jb_en`=0 and `target`=0.
- **JMP:** `jb_en`=1, `target`=LUT[`lut_idx`].
- **BEQ:** taken when `flag_z`=1. **BNE:** taken when `flag_z`=0. When taken, `target`=LUT[`lut_idx`].
- **CALL:**
  - Stack not full: `jb_en`=1, `target`=LUT[`lut_idx`].
  - At the edge, push `prog_ctr`+1 (mod 2^D, so PC=2^D-1 pushes 0) and increment `depth`.
  - Stack full (`depth`=SD): no jump, no push, `stk_ovf` set at the edge.
- **RET:**
  - Stack not empty: `jb_en`=1, `target`=top of stack; pop and decrement `depth` at the edge.
  - Stack empty: no jump, `stk_unf` set at the edge.
- **Reserved or none:** no jump and no state change.
- **LUT write:** when `lut_we`=1, LUT[`lut_waddr`] is written at the edge.
  - A same-cycle read of the same index returns the old value.
  - A LUT write may coincide with any op.
- **Sticky flags:** `stk_ovf` and `stk_unf` are cleared only by reset. Further faults leave them at 1.
- **Stack storage:** the stack is LIFO, implemented as a register array plus pointer. Entries above `depth` are don't-care.
- **Reserved-op coverage:** a reserved op must never assert `jb_en`, modify the stack, or set a flag.

## Timing
- **Reset** (`reset`=0, asynchronous, immediate):
  - `depth`=0, `stk_ovf`=0, `stk_unf`=0.
  - All LUT entries = 0; stack contents = 0.
  - `jb_en` is forced to 0 and `target` to 0 while `reset`=0, regardless of `br_op`.
- **Reset mid-operation:** a CALL or RET in the cycle reset asserts has no effect on the stack after reset releases.
- **Reset release:** state updates resume at the first rising edge with `reset`=1.
- **Latency:** zero cycles from `br_op`/`flag_z`/`lut_idx` to `jb_en`/`target`. The PC samples them at the next edge, so a taken op in cycle N puts `prog_ctr`=`target` in cycle N+1.
- **Stack and LUT updates:** take effect at the edge ending the op's cycle and are visible to the op in cycle N+1.
- **Back-to-back ops:**
  - CALL in cycle N followed by RET in cycle N+1 returns to the pushed address.
  - RET immediately after the last pop sees an empty stack.
- **Simultaneous events:** only one op per cycle exists by construction. LUT write plus JMP to the same index jumps to the old value.

## Test plan
- **Reset:** hold `reset`=0 mid-cycle with `br_op`=001 -> `jb_en`=0, `target`=0, `depth`=0, flags 0 immediately (asynchronously, no clock edge needed).
- **LUT write then JMP:**
  - Write LUT[3]=0x1A5, then JMP idx 3 next cycle -> `jb_en`=1, `target`=0x1A5.
  - Same-cycle write of LUT[3]=0x0F0 with JMP idx 3 -> `target`=0x1A5.
- **Conditional branches:** LUT[5]=0x040.
  - BEQ idx 5 with `flag_z`=1 -> jump to 0x040; with `flag_z`=0 -> `jb_en`=0.
  - BNE is the inverse.
- **CALL/RET nesting:**
  - CALLs at PC=0x010, 0x020, 0x1FF -> `depth`=3.
  - Three RETs -> targets 0x000, 0x021, 0x011 in order; `depth` back to 0.
- **Overflow:** with SD=4, five CALLs ->
  - Fifth CALL: `jb_en`=0, `depth` stays 4, `stk_ovf`=1.
  - Subsequent RET returns the fourth pushed address.
- **Underflow:** RET on empty stack -> `jb_en`=0, `stk_unf`=1 and stays 1 after a later valid CALL/RET pair. Reserved ops 110/111 -> no `jb_en`, no state change.
